// File: rtl/fsqrt_refine.sv
// Newton-Raphson square-root refinement: takes the 6-bit seed from the seed stage
// and iterates Y' = (Y + X/Y)/2 using a bit-serial restoring divider.
module fsqrt_refine #(
    parameter int unsigned ITER = 2,
    parameter int unsigned FRAC = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x,
    input  logic [31:0] y0,
    input  logic        ready,
    output logic        busy,
    output logic        valid,
    output logic [31:0] y
);

    localparam int unsigned CW = $clog2(FRAC + 2);
    localparam int unsigned IW = $clog2(ITER + 1);
    localparam logic [CW-1:0] CNT_INIT  = CW'(FRAC + 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(ITER - 1);

    typedef enum logic [2:0] {IDLE, DIV, UPD, ROUND, DONE} state_t;

    state_t          state_q, state_d;
    logic            sign_q, sign_d;
    logic [7:0]      ye_q, ye_d;
    logic [22:0]     mant_q, mant_d;
    logic [FRAC+1:0] xop_q, xop_d;
    logic [FRAC:0]   yv_q, yv_d;
    logic [FRAC+2:0] rem_q, rem_d;
    logic [FRAC+1:0] quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   it_q, it_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [31:0]     y_q, y_d;

    logic [7:0]      e_in;
    logic [FRAC+1:0] xop_new;
    logic [FRAC+3:0] trial;
    logic            qbit;
    logic [FRAC+1:0] rsel;
    logic [FRAC+2:0] sum;
    logic [23:0]     rnd;

    logic unused_ok;
    assign unused_ok = ^{y0[31:23], y0[16:0], trial[FRAC+2], sum[0]};

    assign e_in    = x[30:23];
    // Odd biased exponent means even unbiased exponent: X = 1.m; otherwise X = 2 * 1.m
    assign xop_new = e_in[0] ? {2'b01, x[22:0], {(FRAC-23){1'b0}}}
                             : {1'b1, x[22:0], {(FRAC-22){1'b0}}};

    // Remainder is kept pre-shifted so each step compares against 2Y
    assign trial = {1'b0, rem_q} - {2'b00, yv_q, 1'b0};
    assign qbit  = ~trial[FRAC+3];
    assign rsel  = qbit ? trial[FRAC+1:0] : rem_q[FRAC+1:0];
    assign sum   = {2'b00, yv_q} + {1'b0, quo_q};
    assign rnd   = {1'b0, yv_q[FRAC-1:FRAC-23]} + 24'(yv_q[FRAC-24]);

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        ye_d    = ye_q;
        mant_d  = mant_q;
        xop_d   = xop_q;
        yv_d    = yv_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        it_d    = it_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        y_d     = y_q;
        unique case (state_q)
            IDLE: begin
                if (ready) begin
                    sign_d = x[31];
                    busy_d = 1'b1;
                    if (e_in == 8'd0) begin
                        ye_d    = 8'd0;
                        mant_d  = '0;
                        state_d = DONE;
                    end else if (e_in == 8'hFF) begin
                        ye_d    = 8'hFF;
                        mant_d  = x[22:0];
                        state_d = DONE;
                    end else begin
                        ye_d    = ((e_in - 8'd1) >> 1) + 8'd64;
                        xop_d   = xop_new;
                        yv_d    = {1'b1, y0[22:17], {(FRAC-6){1'b0}}};
                        rem_d   = {1'b0, xop_new};
                        quo_d   = '0;
                        cnt_d   = CNT_INIT;
                        it_d    = '0;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                rem_d = {rsel, 1'b0};
                quo_d = {quo_q[FRAC:0], qbit};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = UPD;
            end
            UPD: begin
                yv_d = sum[FRAC+1:1];
                it_d = it_q + IW'(1);
                if (it_q != ITER_LAST) begin
                    rem_d   = {1'b0, xop_q};
                    quo_d   = '0;
                    cnt_d   = CNT_INIT;
                    state_d = DIV;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (rnd[23]) begin
                    mant_d = '0;
                    ye_d   = ye_q + 8'd1;
                end else begin
                    mant_d = rnd[22:0];
                end
                state_d = DONE;
            end
            DONE: begin
                y_d     = {sign_q, ye_q, mant_q};
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            ye_q    <= '0;
            mant_q  <= '0;
            xop_q   <= '0;
            yv_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            it_q    <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ye_q    <= ye_d;
            mant_q  <= mant_d;
            xop_q   <= xop_d;
            yv_q    <= yv_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            it_q    <= it_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            y_q     <= y_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign y     = y_q;

endmodule

// File: tb/tb_fsqrt_refine.sv
// Directed and random bench for fsqrt_refine against a real-arithmetic sqrt model.
module tb_fsqrt_refine;

    logic        clk;
    logic        rst;
    logic [31:0] x;
    logic [31:0] y0;
    logic        ready;
    logic        busy;
    logic        valid;
    logic [31:0] y;

    int checks = 0;
    int errors = 0;

    fsqrt_refine #(.ITER(2), .FRAC(25)) dut (
        .clk  (clk),
        .rst  (rst),
        .x    (x),
        .y0   (y0),
        .ready(ready),
        .busy (busy),
        .valid(valid),
        .y    (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic real f2r(input logic [31:0] v);
        logic [10:0] e11;
        e11 = {3'b000, v[30:23]} + 11'd896;
        return $bitstoreal({1'b0, e11, v[22:0], 29'd0});
    endfunction

    // Nearest single-precision sqrt(|v|) for normal v, without the sign
    function automatic logic [30:0] ref_sqrt(input logic [31:0] v);
        logic [63:0] d;
        logic [10:0] e11;
        logic [7:0]  e8;
        d   = $realtobits($sqrt(f2r(v)));
        e11 = d[62:52] - 11'd896;
        e8  = e11[7:0];
        return {e8, d[51:29]} + 31'(d[28]);
    endfunction

    function automatic logic [31:0] model(input logic [31:0] v);
        if (v[30:23] == 8'd0)   return {v[31], 31'd0};
        if (v[30:23] == 8'hFF)  return v;
        return {v[31], ref_sqrt(v)};
    endfunction

    // Seed stage behaviour: top 6 fraction bits of sqrt, other bits are junk
    function automatic logic [31:0] seed_word(input logic [31:0] v);
        logic [31:0] w;
        logic [63:0] d;
        w = $urandom;
        if (v[30:23] != 8'd0 && v[30:23] != 8'hFF) begin
            d = $realtobits($sqrt(f2r(v)));
            w[22:17] = d[51:46];
        end
        return w;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        logic [30:0] diff;
        logic        ok;
        diff = (obs[30:0] > exp[30:0]) ? obs[30:0] - exp[30:0] : exp[30:0] - obs[30:0];
        ok   = (obs[31] === exp[31]) && (diff <= 31'd1) && !$isunknown(obs);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s: got %08h expected %08h +/-1 ulp", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] xv, output logic [31:0] yo,
                          output int lat, output logic b_acc);
        x     = xv;
        y0    = seed_word(xv);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        b_acc = busy;
        lat   = -1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        yo = y;
    endtask

    logic [31:0] yo, xv, yhold;
    int          lat, nval, first, busy_bad;
    logic        b_acc;
    logic [31:0] specials [6];

    initial begin
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h8000_0000;
        specials[2] = 32'h0000_0001;
        specials[3] = 32'h7F80_0000;
        specials[4] = 32'h7FC0_0001;
        specials[5] = 32'hFF80_0000;

        rst = 1'b1; ready = 1'b0; x = '0; y0 = '0;
        tick();
        tick();
        check32("reset_busy", {31'd0, busy}, 32'd0);
        check32("reset_valid", {31'd0, valid}, 32'd0);
        check32("reset_y", y, 32'd0);
        rst = 1'b0;
        tick();

        run_op(32'h4080_0000, yo, lat, b_acc);
        check32("sqrt4_busy", {31'd0, b_acc}, 32'd1);
        check32("sqrt4", yo, 32'h4000_0000);
        check_int("sqrt4_latency", lat, 58);
        check32("sqrt4_busy_done", {31'd0, busy}, 32'd0);

        run_op(32'h4000_0000, yo, lat, b_acc);
        check_near("sqrt2", yo, 32'h3FB5_04F3);
        check_int("sqrt2_latency", lat, 58);

        run_op(32'h3F80_0000, yo, lat, b_acc);
        check32("sqrt1", yo, 32'h3F80_0000);

        run_op(32'hC080_0000, yo, lat, b_acc);
        check32("sqrt_neg4", yo, 32'hC000_0000);

        foreach (specials[i]) begin
            run_op(specials[i], yo, lat, b_acc);
            check32("special", yo, model(specials[i]));
            check_int("special_latency", lat, 1);
        end

        // Requests arriving while busy are dropped
        x = 32'h4080_0000; y0 = seed_word(x); ready = 1'b1;
        tick();
        ready = 1'b0;
        nval = 0; first = -1; busy_bad = 0; yhold = '0;
        for (int c = 1; c <= 100; c++) begin
            if (c == 5 || c == 30) begin
                x = 32'h4110_0000; y0 = seed_word(x); ready = 1'b1;
            end
            tick();
            ready = 1'b0;
            if (valid === 1'b1) begin
                nval++;
                if (first < 0) begin
                    first = c;
                    yhold = y;
                    check32("pulse_busy_at_valid", {31'd0, busy}, 32'd0);
                end
            end else if (first < 0 && busy !== 1'b1) begin
                busy_bad++;
            end
        end
        check_int("pulse_valid_count", nval, 1);
        check_int("pulse_first_valid", first, 58);
        check32("pulse_result", yhold, 32'h4000_0000);
        check_int("pulse_busy_gaps", busy_bad, 0);

        // Reset in the middle of an operation
        x = 32'h4110_0000; y0 = seed_word(x); ready = 1'b1;
        tick();
        ready = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        rst = 1'b1;
        #1;
        check32("midrst_busy", {31'd0, busy}, 32'd0);
        check32("midrst_valid", {31'd0, valid}, 32'd0);
        check32("midrst_y", y, 32'd0);
        tick();
        rst = 1'b0;
        nval = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (valid === 1'b1) nval++;
        end
        check_int("midrst_no_valid", nval, 0);
        run_op(32'h4110_0000, yo, lat, b_acc);
        check_near("after_rst_sqrt9", yo, 32'h4040_0000);
        check_int("after_rst_latency", lat, 58);

        for (int i = 0; i < 600; i++) begin
            logic [7:0]  re;
            logic [22:0] rm;
            logic        rs;
            re = 8'($urandom_range(1, 254));
            rm = 23'($urandom);
            rs = 1'($urandom_range(0, 1));
            xv = {rs, re, rm};
            run_op(xv, yo, lat, b_acc);
            check_near("random", yo, model(xv));
            check_int("random_latency", lat, 58);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
